// File: rtl/vxfer_pkg.sv
// ---------------------------------------------------------------------------
// vxfer_pkg
// Shared definitions for the vector memory transfer engine (vec_mem_xfer).
//   - vxfer_state_e : controller states
//   - OP_LOAD/OP_STORE : encodings of the Op input
//   - clog2() : ceiling log2, used to size the lane counter
// Optional feature macro used by this slice: VXFER_STRIDE_EN
// (see vxfer_addr_gen.sv).
// ---------------------------------------------------------------------------
package vxfer_pkg;

  // Transfer controller states. LOAD and STORE issue requests; DRAIN waits
  // for the last read beat; FIN produces the one-cycle Done pulse.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    STORE = 3'd3,
    FIN   = 3'd4
  } vxfer_state_e;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // Ceiling log2 of n. Returns 0 for n <= 1, so callers that need at least
  // one bit must clamp the result themselves.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vxfer_addr_gen.sv
// ---------------------------------------------------------------------------
// vxfer_addr_gen
// Address accumulator for the vector transfer engine. The accumulator value
// is the memory address output directly, so the address is registered.
//
// Ports:
//   clk       in   clock, all updates on posedge
//   rst       in   asynchronous active-high reset, clears address to 0
//   i_load    in   load i_base (and the stride) into the accumulator
//   i_step    in   request accepted: advance the accumulator by one element
//   i_base    in   [ADDR_W] address of lane 0
//   i_stride  in   [ADDR_W] two's-complement element stride
//   o_addr    out  [ADDR_W] current element address
//
// Configuration macro VXFER_STRIDE_EN:
//   defined   - stride is latched on i_load and added on every step
//   undefined - i_stride is ignored, the accumulator is a plain +1
//               incrementer (unit stride only)
// Address arithmetic is modulo 2^ADDR_W in both directions.
// ---------------------------------------------------------------------------
module vxfer_addr_gen
  import vxfer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

`ifdef VXFER_STRIDE_EN

  logic [ADDR_W-1:0] r_stride;

  // Stride is captured together with the base so that the port may change
  // freely while a transfer is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride <= '0;
    end else if (i_load) begin
      r_stride <= i_stride;
    end
  end

  // Running accumulator: Addr(k+1) = Addr(k) + stride, wrapping silently.
  // A negative stride is just a large unsigned addend here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_step) begin
      r_addr <= r_addr + r_stride;
    end
  end

`else

  // Unit-stride build: the stride input is deliberately not used.
  logic w_unusedStride;
  assign w_unusedStride = ^i_stride;

  // Running accumulator as a simple incrementer, wrapping at 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

`endif

  assign o_addr = r_addr;

endmodule

// File: rtl/vec_mem_xfer.sv
// ---------------------------------------------------------------------------
// vec_mem_xfer
// Moves one vector register image (LANES elements of DATA_W bits) between
// the register-file side and a single-port word memory, one element per
// accepted request, with unit or strided addressing and memory back-pressure.
//
// Parameters: DATA_W (element/word width), LANES (>= 1), ADDR_W.
//
// Ports:
//   Clk       in   clock
//   Reset     in   asynchronous active-high reset, aborts any transfer
//   Start     in   one-cycle request, only sampled in IDLE
//   Op        in   0 = load (memory -> VecOut), 1 = store (VecIn -> memory)
//   BaseAddr  in   [ADDR_W] address of lane 0
//   Stride    in   [ADDR_W] element stride (ignored unless VXFER_STRIDE_EN)
//   VecIn     in   [DATA_W*LANES] store source, lane k = [k*DATA_W +: DATA_W]
//   MemWait   in   memory not accepting the current request this cycle
//   DataIn    in   [DATA_W] read data, valid the cycle after an accepted RD
//   Addr      out  [ADDR_W] memory address
//   RD / WR   out  read / write request (never both high)
//   DataOut   out  [DATA_W] write data
//   VecOut    out  [DATA_W*LANES] load result, complete from Done onwards
//   Busy      out  high whenever the engine is not idle
//   Done      out  one-cycle completion pulse
//
// Configuration macro VXFER_STRIDE_EN: enables the general stride path in
// vxfer_addr_gen; without it addressing is unit-stride only.
//
// All outputs come straight from flops. The output logic below computes the
// value each output must have in the *next* state, and a register stage
// captures it on the same edge that moves the state.
// ---------------------------------------------------------------------------
module vec_mem_xfer
  import vxfer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Op,
  input  logic [ADDR_W-1:0]       BaseAddr,
  input  logic [ADDR_W-1:0]       Stride,
  input  logic [DATA_W*LANES-1:0] VecIn,
  input  logic                    MemWait,
  input  logic [DATA_W-1:0]       DataIn,
  output logic [ADDR_W-1:0]       Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [DATA_W-1:0]       DataOut,
  output logic [DATA_W*LANES-1:0] VecOut,
  output logic                    Busy,
  output logic                    Done
);

  // A one-lane build still needs a one-bit counter.
  localparam int                CNT_W     = (LANES > 1) ? clog2(LANES) : 1;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);

  vxfer_state_e            r_state;
  vxfer_state_e            w_stateNext;

  logic [CNT_W-1:0]        r_lane;
  logic [CNT_W-1:0]        r_capLane;
  logic                    r_pending;
  logic [DATA_W*LANES-1:0] r_vecIn;
  logic [DATA_W*LANES-1:0] r_vecOut;

  logic                    r_rd;
  logic                    r_wr;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_W-1:0]       r_dataOut;

  logic                    w_start;
  logic                    w_accept;
  logic                    w_lastLane;
  logic                    w_rdNext;
  logic                    w_wrNext;
  logic                    w_busyNext;
  logic                    w_doneNext;
  logic [DATA_W-1:0]       w_dataOutNext;
  logic [DATA_W-1:0]       w_storeData;
  logic [ADDR_W-1:0]       w_addr;

  // Start only counts in IDLE; a request is accepted whenever one is being
  // presented (LOAD or STORE) and the memory is not stalling.
  assign w_start    = (r_state == IDLE) && Start;
  assign w_accept   = ((r_state == LOAD) || (r_state == STORE)) && !MemWait;
  assign w_lastLane = (r_lane == LAST_LANE);

  // -------------------------------------------------------------------------
  // Address accumulator: loaded with the base on Start, advanced by one
  // element on every accepted request.
  // -------------------------------------------------------------------------
  vxfer_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (Clk),
    .rst      (Reset),
    .i_load   (w_start),
    .i_step   (w_accept),
    .i_base   (BaseAddr),
    .i_stride (Stride),
    .o_addr   (w_addr)
  );

  // -------------------------------------------------------------------------
  // FSM state register.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic. The state choice made on Start is what records Op,
  // so no separate Op register is kept.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (Start) w_stateNext = (Op == OP_STORE) ? STORE : LOAD;
      end
      LOAD: begin
        if (w_accept && w_lastLane) w_stateNext = DRAIN;
      end
      DRAIN: begin
        w_stateNext = FIN;
      end
      STORE: begin
        if (w_accept && w_lastLane) w_stateNext = FIN;
      end
      FIN: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Store data selector: the element following the one currently on
  // DataOut. A loop over constant lane indices keeps every part-select in
  // range even when the counter sits on the last lane.
  // -------------------------------------------------------------------------
  always_comb begin
    w_storeData = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == int'(r_lane) + 1) w_storeData = r_vecIn[i*DATA_W +: DATA_W];
    end
  end

  // -------------------------------------------------------------------------
  // FSM output logic: next values of the registered outputs. RD/WR simply
  // follow the request states, so they stay high through a stall and are
  // never high together.
  // -------------------------------------------------------------------------
  always_comb begin
    w_rdNext      = (w_stateNext == LOAD);
    w_wrNext      = (w_stateNext == STORE);
    w_busyNext    = (w_stateNext != IDLE);
    w_doneNext    = (w_stateNext == FIN);
    w_dataOutNext = r_dataOut;
    if (w_start && (Op == OP_STORE)) begin
      // Lane 0 comes straight from the port, it is latched on this same edge.
      w_dataOutNext = VecIn[DATA_W-1:0];
    end else if ((r_state == STORE) && w_accept && !w_lastLane) begin
      w_dataOutNext = w_storeData;
    end
  end

  // -------------------------------------------------------------------------
  // Output register stage.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_rd      <= w_rdNext;
      r_wr      <= w_wrNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_dataOut <= w_dataOutNext;
    end
  end

  // -------------------------------------------------------------------------
  // Lane counter, store-source latch and read bookkeeping. r_capLane
  // remembers which lane the accepted read belongs to, because the counter
  // has already moved on by the time the data arrives. r_pending is set only
  // for an accepted read, so a stalled cycle never captures DataIn.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lane    <= '0;
      r_capLane <= '0;
      r_pending <= 1'b0;
      r_vecIn   <= '0;
    end else begin
      if (w_start) begin
        r_lane  <= '0;
        r_vecIn <= VecIn;
      end else if (w_accept) begin
        r_lane  <= r_lane + CNT_W'(1);
      end
      if (w_accept) r_capLane <= r_lane;
      r_pending <= (r_state == LOAD) && w_accept;
    end
  end

  // -------------------------------------------------------------------------
  // Load result register: one lane written per returned read beat. It is
  // not cleared on Start, so it keeps the previous result until overwritten.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vecOut <= '0;
    end else if (r_pending) begin
      for (int i = 0; i < LANES; i++) begin
        if (i == int'(r_capLane)) r_vecOut[i*DATA_W +: DATA_W] <= DataIn;
      end
    end
  end

  assign Addr    = w_addr;
  assign RD      = r_rd;
  assign WR      = r_wr;
  assign DataOut = r_dataOut;
  assign VecOut  = r_vecOut;
  assign Busy    = r_busy;
  assign Done    = r_done;

endmodule

// File: tb/tb_vec_mem_xfer.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_xfer
// Self-checking bench for vec_mem_xfer: a default 16-lane instance plus a
// one-lane instance. Expected traffic is derived from the transfer rules
// (address = base + k*stride, one lane per non-stalled cycle, fixed read
// latency) and compared against per-cycle observations.
// Honours VXFER_STRIDE_EN: without it the expected stride is always +1.
// ---------------------------------------------------------------------------
module tb_vec_mem_xfer;

  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int ADDR_W = 16;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic                    Start;
  logic                    Op;
  logic [ADDR_W-1:0]       BaseAddr;
  logic [ADDR_W-1:0]       Stride;
  logic [DATA_W*LANES-1:0] VecIn;
  logic                    MemWait;
  logic [DATA_W-1:0]       DataIn;
  logic [ADDR_W-1:0]       Addr;
  logic                    RD;
  logic                    WR;
  logic [DATA_W-1:0]       DataOut;
  logic [DATA_W*LANES-1:0] VecOut;
  logic                    Busy;
  logic                    Done;

  logic                    Start1;
  logic [DATA_W-1:0]       VecIn1;
  logic [DATA_W-1:0]       DataIn1;
  logic [ADDR_W-1:0]       Addr1;
  logic                    RD1;
  logic                    WR1;
  logic [DATA_W-1:0]       DataOut1;
  logic [DATA_W-1:0]       VecOut1;
  logic                    Busy1;
  logic                    Done1;

  int                      nChecks = 0;
  int                      nFails  = 0;
  logic [DATA_W-1:0]       memKey  = '0;

  // Observations per cycle of a transfer (cycle 0 = after the Start edge).
  logic                    obsRd   [64];
  logic                    obsWr   [64];
  logic                    obsDone [64];
  logic                    obsBusy [64];
  logic [ADDR_W-1:0]       obsAddr [64];
  logic [DATA_W-1:0]       obsData [64];

  // Reference model results.
  bit                      expReq   [64];
  int                      expLane  [64];
  logic [ADDR_W-1:0]       expAddr  [64];
  logic [ADDR_W-1:0]       laneAddr [LANES];
  int                      expDone;

  always #5 Clk = ~Clk;

  vec_mem_xfer #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr),
    .Stride(Stride), .VecIn(VecIn), .MemWait(MemWait), .DataIn(DataIn),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .VecOut(VecOut),
    .Busy(Busy), .Done(Done)
  );

  vec_mem_xfer #(.DATA_W(DATA_W), .LANES(1), .ADDR_W(ADDR_W)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start1), .Op(Op), .BaseAddr(BaseAddr),
    .Stride(Stride), .VecIn(VecIn1), .MemWait(MemWait), .DataIn(DataIn1),
    .Addr(Addr1), .RD(RD1), .WR(WR1), .DataOut(DataOut1), .VecOut(VecOut1),
    .Busy(Busy1), .Done(Done1)
  );

  // Memory: an accepted read returns addr ^ memKey one cycle later; any
  // other cycle presents garbage so stale data can never look correct.
  always @(posedge Clk) begin
    if (RD && !MemWait) DataIn <= Addr ^ memKey;
    else                DataIn <= DATA_W'($urandom);
    if (RD1 && !MemWait) DataIn1 <= Addr1 ^ memKey;
    else                 DataIn1 <= DATA_W'($urandom);
  end

  // Transfer rules: lane k lives at base + k*stride (mod 2^16); the request
  // for the current lane is presented every cycle until a non-stalled cycle
  // takes it. Done follows the last acceptance by 2 cycles (load) or 1
  // cycle (store).
  task automatic buildModel(input bit op, input logic [15:0] base,
                            input logic [15:0] stride, input bit [63:0] mask);
    logic [15:0] eff;
    int k, c;
    eff = stride;
`ifndef VXFER_STRIDE_EN
    eff = 16'd1;
`endif
    for (int i = 0; i < LANES; i++) laneAddr[i] = base + 16'(i) * eff;
    for (int i = 0; i < 64; i++) begin
      expReq[i] = 1'b0; expLane[i] = 0; expAddr[i] = '0;
    end
    k = 0; c = 0;
    while (k < LANES && c < 64) begin
      expReq[c]  = 1'b1;
      expLane[c] = k;
      expAddr[c] = laneAddr[k];
      if (!mask[c]) k++;
      c++;
    end
    expDone = op ? c : c + 1;
  endtask

  // Runs one transfer on the 16-lane instance and records every cycle.
  // Called at a falling edge; returns at the falling edge of cycle ncyc.
  // poke >= 0 pulses Start (with the opposite Op) in that cycle.
  task automatic doXfer(input bit op, input logic [15:0] base,
                        input logic [15:0] stride, input logic [255:0] vin,
                        input bit [63:0] mask, input int ncyc, input int poke);
    Op = op; BaseAddr = base; Stride = stride; VecIn = vin;
    MemWait = 1'b0; Start = 1'b1;
    @(negedge Clk);
    for (int c = 0; c < ncyc; c++) begin
      obsRd[c] = RD; obsWr[c] = WR; obsDone[c] = Done; obsBusy[c] = Busy;
      obsAddr[c] = Addr; obsData[c] = DataOut;
      MemWait = mask[c];
      if (c == poke) begin Start = 1'b1; Op = ~op; end
      else Start = 1'b0;
      @(negedge Clk);
    end
    Start = 1'b0; MemWait = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    nChecks++; if (Addr !== 16'h0) begin nFails++; $display("[TB] FAIL reset_addr got %h want 0000", Addr); end
    nChecks++; if (RD !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rd got %b want 0", RD); end
    nChecks++; if (WR !== 1'b0) begin nFails++; $display("[TB] FAIL reset_wr got %b want 0", WR); end
    nChecks++; if (DataOut !== 16'h0) begin nFails++; $display("[TB] FAIL reset_dataout got %h want 0000", DataOut); end
    nChecks++; if (VecOut !== '0) begin nFails++; $display("[TB] FAIL reset_vecout got %h want 0", VecOut); end
    nChecks++; if (Busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    nChecks++; if (Done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", Done); end
    Reset = 1'b0;
  endtask

  task automatic test_load(input logic [15:0] base, input logic [15:0] stride,
                           input bit [63:0] mask, input logic [15:0] key,
                           input int poke, input int tail, input string tag);
    logic [255:0] expVec;
    int ncyc;
    memKey = key;
    buildModel(1'b0, base, stride, mask);
    ncyc = expDone + 1 + tail;
    doXfer(1'b0, base, stride, 256'($urandom), mask, ncyc, poke);
    for (int c = 0; c < ncyc; c++) begin
      nChecks++;
      if (obsRd[c] !== expReq[c]) begin nFails++; $display("[TB] FAIL %s_rd cycle %0d got %b want %b", tag, c, obsRd[c], expReq[c]); end
      if (expReq[c]) begin
        nChecks++;
        if (obsAddr[c] !== expAddr[c]) begin nFails++; $display("[TB] FAIL %s_addr cycle %0d got %h want %h", tag, c, obsAddr[c], expAddr[c]); end
      end
      nChecks++;
      if (obsWr[c] !== 1'b0) begin nFails++; $display("[TB] FAIL %s_wr cycle %0d got %b want 0", tag, c, obsWr[c]); end
      nChecks++;
      if (obsDone[c] !== (c == expDone)) begin nFails++; $display("[TB] FAIL %s_done cycle %0d got %b want %b", tag, c, obsDone[c], (c == expDone)); end
      nChecks++;
      if (obsBusy[c] !== (c <= expDone)) begin nFails++; $display("[TB] FAIL %s_busy cycle %0d got %b want %b", tag, c, obsBusy[c], (c <= expDone)); end
    end
    for (int k = 0; k < LANES; k++) expVec[k*16 +: 16] = laneAddr[k] ^ key;
    nChecks++;
    if (VecOut !== expVec) begin nFails++; $display("[TB] FAIL %s_vecout got %h want %h", tag, VecOut, expVec); end
  endtask

  task automatic test_store(input logic [15:0] base, input logic [15:0] stride,
                            input logic [255:0] vin, input bit [63:0] mask,
                            input int tail, input string tag);
    int ncyc;
    logic [15:0] want;
    buildModel(1'b1, base, stride, mask);
    ncyc = expDone + 1 + tail;
    doXfer(1'b1, base, stride, vin, mask, ncyc, -1);
    for (int c = 0; c < ncyc; c++) begin
      nChecks++;
      if (obsWr[c] !== expReq[c]) begin nFails++; $display("[TB] FAIL %s_wr cycle %0d got %b want %b", tag, c, obsWr[c], expReq[c]); end
      if (expReq[c]) begin
        want = vin[expLane[c]*16 +: 16];
        nChecks++;
        if (obsAddr[c] !== expAddr[c]) begin nFails++; $display("[TB] FAIL %s_addr cycle %0d got %h want %h", tag, c, obsAddr[c], expAddr[c]); end
        nChecks++;
        if (obsData[c] !== want) begin nFails++; $display("[TB] FAIL %s_data cycle %0d got %h want %h", tag, c, obsData[c], want); end
      end
      nChecks++;
      if (obsRd[c] !== 1'b0) begin nFails++; $display("[TB] FAIL %s_rd cycle %0d got %b want 0", tag, c, obsRd[c]); end
      nChecks++;
      if (obsDone[c] !== (c == expDone)) begin nFails++; $display("[TB] FAIL %s_done cycle %0d got %b want %b", tag, c, obsDone[c], (c == expDone)); end
      nChecks++;
      if (obsBusy[c] !== (c <= expDone)) begin nFails++; $display("[TB] FAIL %s_busy cycle %0d got %b want %b", tag, c, obsBusy[c], (c <= expDone)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] vin;
    vin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    Op = 1'b1; BaseAddr = 16'h0400; Stride = 16'h0001; VecIn = vin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    nChecks++; if (WR !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_wr_before got %b want 1", WR); end
    Reset = 1'b1;
    #1;
    nChecks++; if (WR !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_wr got %b want 0", WR); end
    nChecks++; if (Busy !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_busy got %b want 0", Busy); end
    nChecks++; if (Addr !== 16'h0) begin nFails++; $display("[TB] FAIL rstmid_addr got %h want 0000", Addr); end
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      nChecks++; if (Done !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_done got %b want 0", Done); end
    end
    Reset = 1'b0;
    test_store(16'h0500, 16'h0001, vin, 64'h0, 1, "after_reset");
  endtask

  task automatic test_lanes1();
    logic [15:0] base, vin1;
    base = 16'($urandom); vin1 = 16'($urandom); memKey = 16'($urandom);
    Op = 1'b0; BaseAddr = base; MemWait = 1'b0; Start1 = 1'b1;
    @(negedge Clk); Start1 = 1'b0;
    nChecks++; if (RD1 !== 1'b1 || Addr1 !== base) begin nFails++; $display("[TB] FAIL l1_load_req got rd=%b addr=%h want rd=1 addr=%h", RD1, Addr1, base); end
    @(negedge Clk);
    nChecks++; if (RD1 !== 1'b0 || Done1 !== 1'b0) begin nFails++; $display("[TB] FAIL l1_load_c1 got rd=%b done=%b want 0 0", RD1, Done1); end
    @(negedge Clk);
    nChecks++; if (Done1 !== 1'b1) begin nFails++; $display("[TB] FAIL l1_load_done got %b want 1", Done1); end
    nChecks++; if (VecOut1 !== (base ^ memKey)) begin nFails++; $display("[TB] FAIL l1_vecout got %h want %h", VecOut1, base ^ memKey); end
    // Back-to-back store issued in the cycle after Done.
    @(negedge Clk);
    nChecks++; if (Done1 !== 1'b0 || Busy1 !== 1'b0) begin nFails++; $display("[TB] FAIL l1_idle got done=%b busy=%b want 0 0", Done1, Busy1); end
    Op = 1'b1; VecIn1 = vin1; Start1 = 1'b1;
    @(negedge Clk); Start1 = 1'b0;
    nChecks++; if (WR1 !== 1'b1 || Addr1 !== base || DataOut1 !== vin1) begin nFails++; $display("[TB] FAIL l1_store_req got wr=%b addr=%h data=%h want 1 %h %h", WR1, Addr1, DataOut1, base, vin1); end
    @(negedge Clk);
    nChecks++; if (Done1 !== 1'b1 || WR1 !== 1'b0) begin nFails++; $display("[TB] FAIL l1_store_done got done=%b wr=%b want 1 0", Done1, WR1); end
    @(negedge Clk);
    nChecks++; if (Done1 !== 1'b0) begin nFails++; $display("[TB] FAIL l1_store_after got %b want 0", Done1); end
  endtask

  task automatic test_random();
    bit [63:0] mask;
    logic [255:0] vin;
    for (int n = 0; n < 6; n++) begin
      mask = '0;
      for (int c = 0; c < 40; c++) mask[c] = ($urandom_range(0, 3) == 0);
      vin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        test_store(16'($urandom), 16'($urandom), vin, mask, 1, "rand_store");
      else
        test_load(16'($urandom), 16'($urandom), mask, 16'($urandom), -1, 1, "rand_load");
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] vin;
    vin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    // Start pulsed in cycle 3 of a load must be ignored; the store starts
    // in the cycle right after Done.
    test_load(16'h0300, 16'h0001, 64'h0, 16'h5A5A, 3, 0, "b2b_load");
    test_store(16'h0700, 16'h0002, vin, 64'h0, 1, "b2b_store");
  endtask

  initial begin
    logic [255:0] vinRamp;
    Reset = 1'b1; Start = 1'b0; Start1 = 1'b0; Op = 1'b0; BaseAddr = '0;
    Stride = '0; VecIn = '0; VecIn1 = '0; MemWait = 1'b0;
    for (int k = 0; k < LANES; k++) vinRamp[k*16 +: 16] = 16'(k * 16'h1111);

    test_reset();
    test_load(16'h0100, 16'h0001, 64'h0, 16'hA5A5, -1, 1, "load_unit");
    test_store(16'h0200, 16'h0003, vinRamp, 64'h0, 1, "store_stride");
    test_load(16'h0100, 16'h0001, 64'h0204, 16'hA5A5, -1, 1, "load_stall");
    test_load(16'hFFFE, 16'hFFFF, 64'h0, 16'h3C3C, -1, 1, "wrap_neg");
    test_load(16'hFFFE, 16'h0002, 64'h0, 16'hC3C3, -1, 1, "wrap_pos");
    test_reset_mid();
    test_back_to_back();
    test_lanes1();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
